// File: rtl/l2_adapter_pkg.sv
// l2_adapter_pkg: shared widths and FSM state encodings for the L2 memory burst adapter.
package l2_adapter_pkg;
   localparam int LINE_BITS  = 256;
   localparam int BURST_BITS = 64;
   localparam int NUM_BEATS  = 4;
   localparam int BEAT_IDX_W = 2;
   typedef logic [1:0] state_t;
   localparam state_t IDLE     = 2'd0;
   localparam state_t RD_BURST = 2'd1;
   localparam state_t WR_BURST = 2'd2;
   localparam state_t DONE     = 2'd3;
endpackage

// File: rtl/l2_beat_buffer.sv
// l2_beat_buffer: 256-bit line buffer with a 2-bit beat counter, filled or drained one 64-bit beat at a time.
module l2_beat_buffer
   import l2_adapter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_line,
   input  logic                  load_beat,
   input  logic                  advance,
   input  logic                  clear,
   input  logic [LINE_BITS-1:0]  wr_line,
   input  logic [BURST_BITS-1:0] rd_beat,
   output logic [BEAT_IDX_W-1:0] beat_idx,
   output logic [BURST_BITS-1:0] beat_word,
   output logic [LINE_BITS-1:0]  line_data
);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         beat_idx  <= '0;
         line_data <= '0;
      end else begin
         if (load_line) line_data <= wr_line;
         else if (load_beat) line_data[beat_idx*BURST_BITS +: BURST_BITS] <= rd_beat;
         beat_idx <= clear ? '0 : advance ? beat_idx + 1'b1 : beat_idx;
      end
   assign beat_word = line_data[beat_idx*BURST_BITS +: BURST_BITS];
endmodule

// File: rtl/l2_mem_burst_adapter.sv
// l2_mem_burst_adapter: converts L2 256-bit line requests into 4-beat 64-bit memory bursts.
// Define L2_ADAPTER_PERF_EN to build the completed-read/write performance counters.
module l2_mem_burst_adapter
   import l2_adapter_pkg::*;
#(
   parameter int s_offset = 5,
   parameter int s_burst  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           line_addr_i,
   input  logic                  line_read_i,
   input  logic                  line_write_i,
   input  logic [LINE_BITS-1:0]  line_wdata_i,
   output logic [LINE_BITS-1:0]  line_rdata_o,
   output logic                  line_resp_o,
   output logic [31:0]           mem_addr_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic [s_burst-1:0]    mem_wdata_o,
   input  logic [s_burst-1:0]    mem_rdata_i,
   input  logic                  mem_resp_i,
   output logic [31:0]           perf_rd_cnt_o,
   output logic [31:0]           perf_wr_cnt_o
);
   state_t                  state, state_next;
   logic [31:0]             addr_q;
   logic [BEAT_IDX_W-1:0]   beat_idx;
   logic                    accept, last;
   logic                    unused;
   assign unused = ^line_addr_i[s_offset-1:0];
   assign accept = state == IDLE && (line_read_i || line_write_i);
   assign last   = mem_resp_i && beat_idx == BEAT_IDX_W'(NUM_BEATS-1);
   always_comb
      state_next = state == IDLE ? (line_read_i ? RD_BURST : line_write_i ? WR_BURST : IDLE)
                 : state == DONE ? IDLE
                 : last          ? DONE : state;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         addr_q <= '0;
      end else begin
         state <= state_next;
         if (accept) addr_q <= {line_addr_i[31:s_offset], {s_offset{1'b0}}};
      end
   l2_beat_buffer u_buf (
      .clk       (clk),
      .rst       (rst),
      .load_line (state == IDLE && !line_read_i && line_write_i),
      .load_beat (state == RD_BURST && mem_resp_i),
      .advance   ((state == RD_BURST || state == WR_BURST) && mem_resp_i),
      .clear     (state == IDLE),
      .wr_line   (line_wdata_i),
      .rd_beat   (mem_rdata_i),
      .beat_idx  (beat_idx),
      .beat_word (mem_wdata_o),
      .line_data (line_rdata_o)
   );
   assign mem_addr_o  = addr_q;
   assign mem_read_o  = state == RD_BURST;
   assign mem_write_o = state == WR_BURST;
   assign line_resp_o = state == DONE;
`ifdef L2_ADAPTER_PERF_EN
   logic rd_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_q          <= 1'b0;
         perf_rd_cnt_o <= '0;
         perf_wr_cnt_o <= '0;
      end else begin
         if (accept) rd_q <= line_read_i;
         if (state == DONE) begin
            perf_rd_cnt_o <= perf_rd_cnt_o + {31'b0, rd_q};
            perf_wr_cnt_o <= perf_wr_cnt_o + {31'b0, !rd_q};
         end
      end
`else
   assign perf_rd_cnt_o = '0;
   assign perf_wr_cnt_o = '0;
`endif
endmodule
